// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN datapath blocks.
//   - stream_state_t : two-state streaming FSM encoding (IDLE, STREAM)
//   - TGT_HIGH_FILL / TGT_LOW_FILL : default target encodings. Consumers
//     slice these to their own lane width so that the target streamer and
//     the error-computation block agree on what "hit" and "miss" look like.
//   - clog2_min1 : ceil(log2(n)) but never below 1, so that index ports stay
//     at least one bit wide for degenerate sizes (N=1, single-beat vectors).
package dnn_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    localparam logic [63:0] TGT_HIGH_FILL = {64{1'b1}};
    localparam logic [63:0] TGT_LOW_FILL  = {64{1'b0}};

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/target_beat_encoder.sv
// Combinational expansion of a class label into one beat of a one-hot
// target vector.
//   label_q : class index being expanded (may be out of range; then no lane
//             matches and the whole beat is LOW_VAL)
//   beat    : beat index; lane i of this beat covers class beat*z + i
//   lanes   : width*z lane word, lane 0 in the least significant bits
// Shared with the loss unit, so it carries no state of its own.
module target_beat_encoder
    import dnn_pkg::*;
#(
    parameter int              width    = 4,
    parameter int              z        = 8,
    parameter int              LW       = 5,
    parameter int              BW       = 2,
    parameter logic [width-1:0] HIGH_VAL = TGT_HIGH_FILL[width-1:0],
    parameter logic [width-1:0] LOW_VAL  = TGT_LOW_FILL[width-1:0]
) (
    input  logic [LW-1:0]      label_q,
    input  logic [BW-1:0]      beat,
    output logic [width*z-1:0] lanes
);

    // Class index of lane 0 of this beat. Done in 32 bits so that an
    // out-of-range label can never alias onto a real lane.
    logic [31:0] base;

    assign base = 32'(beat) * 32'(z);

    generate
        for (genvar gi = 0; gi < z; gi++) begin : g_lane
            assign lanes[width*gi +: width] =
                ((base + 32'(gi)) == 32'(label_q)) ? HIGH_VAL : LOW_VAL;
        end
    endgenerate

endmodule

// File: rtl/label_target_streamer.sv
// Expands a class label into an N-entry target vector (HIGH_VAL at the label
// position, LOW_VAL elsewhere) and streams it as N/z beats of z lanes.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   label_valid  : label offered          label_ready : label accepted this cycle
//   label        : class index 0..N-1     label_err   : vector came from label >= N
//   out_valid    : beat present           out_ready   : downstream takes the beat
//   out          : lane i at [width*(i+1)-1 : width*i], lane 0 = lowest class
//   out_beat     : beat index 0..NB-1     out_last    : high on beat NB-1
// A new label is only taken in IDLE or while the last beat is being accepted,
// which gives back-to-back vectors with no bubble between them.
module label_target_streamer
    import dnn_pkg::*;
#(
    parameter int               width    = 4,
    parameter int               N        = 32,
    parameter int               z        = 8,
    parameter logic [width-1:0] HIGH_VAL = TGT_HIGH_FILL[width-1:0],
    parameter logic [width-1:0] LOW_VAL  = TGT_LOW_FILL[width-1:0],
    parameter int               LW       = clog2_min1(N),
    parameter int               NB       = (z > 0) ? (N / z) : 1,
    parameter int               BW       = clog2_min1(NB)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               label_valid,
    output logic               label_ready,
    input  logic [LW-1:0]      label,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [width*z-1:0] out,
    output logic [BW-1:0]      out_beat,
    output logic               out_last,
    output logic               label_err
);

    generate
        if (z < 1) begin : g_bad_z
            $error("label_target_streamer: z must be at least 1");
        end else if ((N % z) != 0) begin : g_bad_n
            $error("label_target_streamer: N must be a multiple of z");
        end
        if (HIGH_VAL == LOW_VAL) begin : g_bad_vals
            $error("label_target_streamer: HIGH_VAL must differ from LOW_VAL");
        end
    endgenerate

    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
    // One bit wider than the label so the range test is meaningful even when
    // N is a power of two (the label then simply can never reach it).
    localparam logic [LW:0]   N_EXT     = (LW + 1)'(N);

    stream_state_t      state_reg, state_next;
    logic [LW-1:0]      label_reg, label_next;
    logic [BW-1:0]      beat_reg, beat_next;
    logic [width*z-1:0] lanes_next;
    logic               last_beat;

    assign last_beat = (state_reg == STREAM) && (beat_reg == LAST_BEAT);

    // On the last beat the label port mirrors out_ready, so the next label is
    // taken on the very edge that retires the final beat.
    assign label_ready = (state_reg == IDLE) || (last_beat && out_ready);

    always_comb begin
        state_next = state_reg;
        label_next = label_reg;
        beat_next  = beat_reg;
        case (state_reg)
            IDLE: begin
                if (label_valid) begin
                    state_next = STREAM;
                    label_next = label;
                    beat_next  = '0;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (!last_beat) begin
                        beat_next = beat_reg + 1'b1;
                    end else if (label_valid) begin
                        label_next = label;
                        beat_next  = '0;
                    end else begin
                        state_next = IDLE;
                        beat_next  = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                beat_next  = '0;
            end
        endcase
    end

    // Encode from the next-state values so the registered outputs line up
    // with the state they describe; stalls leave label/beat untouched and the
    // outputs therefore hold.
    target_beat_encoder #(
        .width   (width),
        .z       (z),
        .LW      (LW),
        .BW      (BW),
        .HIGH_VAL(HIGH_VAL),
        .LOW_VAL (LOW_VAL)
    ) u_encoder (
        .label_q(label_next),
        .beat   (beat_next),
        .lanes  (lanes_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            label_reg <= '0;
            beat_reg  <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            out_beat  <= '0;
            out_last  <= 1'b0;
            label_err <= 1'b0;
        end else begin
            state_reg <= state_next;
            label_reg <= label_next;
            beat_reg  <= beat_next;
            if (state_next == STREAM) begin
                out_valid <= 1'b1;
                out       <= lanes_next;
                out_beat  <= beat_next;
                out_last  <= (beat_next == LAST_BEAT);
                label_err <= ({1'b0, label_next} >= N_EXT);
            end else begin
                out_valid <= 1'b0;
                out       <= '0;
                out_beat  <= '0;
                out_last  <= 1'b0;
                label_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_label_target_streamer.sv
// Three instances share one clock and reset:
//   inst0 : N=32, z=8 (four beats, power-of-two class count)
//   inst1 : N=24, z=8 (three beats, labels 24..31 are illegal)
//   inst2 : N=8,  z=8 (single-beat vectors)
// The stimulus side offers labels; every accepted label pushes the expected
// beats into a per-instance queue. A monitor on the falling edge compares
// whatever the DUT presents against the queue front.
module tb_label_target_streamer;

    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  beat;
        logic        last;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        lv   [3];
    logic        lr   [3];
    logic [4:0]  lbl  [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [31:0] ow   [3];
    logic [1:0]  ob   [3];
    logic        olast[3];
    logic        oerr [3];

    logic [2:0]  lbl8;
    logic        ob8;

    int          n_of [3] = '{32, 24, 8};
    exp_t        exp_q[3][$];
    int          pend [3][$];
    logic [31:0] cap  [3][$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    bit          rand_mode = 0;
    int          cyc = 0;

    assign lbl8  = lbl[2][2:0];
    assign ob[2] = {1'b0, ob8};

    label_target_streamer #(.width(4), .N(32), .z(8)) u_dut32 (
        .clk(clk), .reset(rst),
        .label_valid(lv[0]), .label_ready(lr[0]), .label(lbl[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out(ow[0]),
        .out_beat(ob[0]), .out_last(olast[0]), .label_err(oerr[0])
    );

    label_target_streamer #(.width(4), .N(24), .z(8)) u_dut24 (
        .clk(clk), .reset(rst),
        .label_valid(lv[1]), .label_ready(lr[1]), .label(lbl[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out(ow[1]),
        .out_beat(ob[1]), .out_last(olast[1]), .label_err(oerr[1])
    );

    label_target_streamer #(.width(4), .N(8), .z(8)) u_dut8 (
        .clk(clk), .reset(rst),
        .label_valid(lv[2]), .label_ready(lr[2]), .label(lbl8),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out(ow[2]),
        .out_beat(ob8), .out_last(olast[2]), .label_err(oerr[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s inst%0d got %h expected %h at %0t", nm, k, got, expv, $time);
        end
    endtask

    // Reference model: a label L of an N-class vector lands in beat L/8,
    // lane L%8; an out-of-range label produces an all-zero vector with err.
    task automatic push_vector(input int k, input int l);
        int   nb;
        exp_t e;
        nb = n_of[k] / 8;
        for (int b = 0; b < nb; b++) begin
            e.word = 32'h0;
            if (l < n_of[k] && (l / 8) == b) begin
                e.word = 32'hF;
                e.word = e.word << (4 * (l % 8));
            end
            e.beat = 2'(b);
            e.last = (b == nb - 1);
            e.err  = (l >= n_of[k]);
            exp_q[k].push_back(e);
        end
    endtask

    // Stimulus driver: inputs change 1 time unit after the rising edge.
    initial begin
        for (int k = 0; k < 3; k++) begin
            lv[k] = 1'b0; lbl[k] = '0; ordy[k] = 1'b1;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < 3; k++) begin
                case (rdy_mode)
                    1:       ordy[k] = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                    2:       ordy[k] = ($urandom % 4) != 0;
                    default: ordy[k] = 1'b1;
                endcase
                if (rand_mode) begin
                    lv[k]  = ($urandom % 3) != 0;
                    lbl[k] = (k == 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                end else if (pend[k].size() > 0) begin
                    lv[k]  = 1'b1;
                    lbl[k] = 5'(pend[k][0]);
                end else begin
                    lv[k]  = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard. The queue holds exactly the beats still owed for
    // the vector in flight, so its size also determines valid and ready.
    initial begin
        int   qs;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < 3; k++) begin
                    qs = exp_q[k].size();
                    chk("label_ready", k, 32'(lr[k]), 32'((qs == 0) || (qs == 1 && ordy[k])));
                    chk("out_valid", k, 32'(ov[k]), 32'(qs != 0));
                    if (qs != 0 && ov[k]) begin
                        e = exp_q[k][0];
                        chk("out", k, ow[k], e.word);
                        chk("out_beat", k, 32'(ob[k]), 32'(e.beat));
                        chk("out_last", k, 32'(olast[k]), 32'(e.last));
                        chk("label_err", k, 32'(oerr[k]), 32'(e.err));
                        if (ordy[k]) begin
                            void'(exp_q[k].pop_front());
                            cap[k].push_back(ow[k]);
                        end
                    end
                    if (lv[k] && lr[k]) begin
                        if (!rand_mode && pend[k].size() > 0) void'(pend[k].pop_front());
                        $display("inst%0d label %0d accepted at %0t", k, lbl[k], $time);
                        push_vector(k, int'(lbl[k]));
                    end
                end
            end
        end
    end

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            done = 1'b1;
            for (int k = 0; k < 3; k++)
                if (pend[k].size() != 0 || exp_q[k].size() != 0 || ov[k]) done = 1'b0;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout vectors still outstanding at %0t", $time);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_caps();
        for (int k = 0; k < 3; k++) cap[k].delete();
    endtask

    initial begin
        bit found;
        rst = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", k, 32'(ov[k]), 32'h0);
            chk("rst_out", k, ow[k], 32'h0);
            chk("rst_out_beat", k, 32'(ob[k]), 32'h0);
            chk("rst_out_last", k, 32'(olast[k]), 32'h0);
            chk("rst_label_err", k, 32'(oerr[k]), 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single label 5 on N=32
        clear_caps();
        pend[0].push_back(5);
        drain();
        chk("l5_beats", 0, 32'(cap[0].size()), 32'd4);
        if (cap[0].size() == 4) begin
            chk("l5_b0", 0, cap[0][0], 32'h00F00000);
            chk("l5_b1", 0, cap[0][1], 32'h0);
            chk("l5_b3", 0, cap[0][3], 32'h0);
        end

        // Label 31 under a stalling sink
        clear_caps();
        rdy_mode = 1;
        pend[0].push_back(31);
        drain();
        rdy_mode = 0;
        chk("l31_beats", 0, 32'(cap[0].size()), 32'd4);
        if (cap[0].size() == 4) chk("l31_b3", 0, cap[0][3], 32'hF0000000);

        // Back-to-back labels 0 then 8
        clear_caps();
        pend[0].push_back(0);
        pend[0].push_back(8);
        drain();
        chk("b2b_beats", 0, 32'(cap[0].size()), 32'd8);
        if (cap[0].size() == 8) begin
            chk("b2b_v0b0", 0, cap[0][0], 32'h0000000F);
            chk("b2b_v1b1", 0, cap[0][5], 32'h0000000F);
        end

        // Illegal label 27 then 23 on N=24
        clear_caps();
        pend[1].push_back(27);
        pend[1].push_back(23);
        drain();
        chk("n24_beats", 1, 32'(cap[1].size()), 32'd6);
        if (cap[1].size() == 6) begin
            chk("n24_illegal_b0", 1, cap[1][0], 32'h0);
            chk("n24_illegal_b2", 1, cap[1][2], 32'h0);
            chk("n24_l23_b2", 1, cap[1][5], 32'hF0000000);
        end

        // Single-beat vector, N=8
        clear_caps();
        pend[2].push_back(3);
        drain();
        chk("n8_beats", 2, 32'(cap[2].size()), 32'd1);
        if (cap[2].size() == 1) chk("n8_b0", 2, cap[2][0], 32'h0000F000);

        // Reset in the middle of a vector
        pend[0].push_back(12);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (ov[0] && ob[0] == 2'd1) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL reset_setup beat 1 never seen at %0t", $time);
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk("async_rst_valid", k, 32'(ov[k]), 32'h0);
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            pend[k].delete();
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 0, 32'(lr[0]), 32'h1);
        repeat (6) @(negedge clk);

        // Recovery, then randomized traffic on every instance
        pend[0].push_back(17);
        drain();
        rand_mode = 1'b1;
        rdy_mode  = 2;
        repeat (800) @(posedge clk);
        rand_mode = 1'b0;
        rdy_mode  = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
